// File: rtl/uart_rx_fifo_if.sv
// Register bus bundle for the UART receive FIFO.
// The host side drives address/data/strobe; the block returns read data and irq.
interface uart_rx_fifo_if;
    logic [5:0]  addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic [31:0] data_out;
    logic        irq;

    modport master (
        output addr,
        output data_in,
        output write_enable,
        input  data_out,
        input  irq
    );

    modport slave (
        input  addr,
        input  data_in,
        input  write_enable,
        output data_out,
        output irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO, exposed through a small register map.
// Framing and overrun errors are sticky flags cleared by write-one-to-clear.
module uart_rx_fifo #(
    parameter int UART_PERIOD = 5,
    parameter int DEPTH       = 16
) (
    input logic          clk,
    input logic          rst,
    input logic          rx,
    uart_rx_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(UART_PERIOD);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bits_q, bits_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, sync2_q;
    logic          rxs;
    logic          push, ferr_set;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [5:0]    count_q, count_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q, ferr_d;

    logic          empty, full;
    logic          wr_status, wr_pop;
    logic          pop, push_ok, ovr_set;
    logic          unused_ok;

    assign rxs = sync2_q;

    // Synchronizer idles high so reset never fakes a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            bits_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TW'(1);
        bits_d   = bits_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (timer_q == TW'(UART_PERIOD / 2 - 1)) begin
                    timer_d = '0;
                    bits_d  = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == TW'(UART_PERIOD - 1)) begin
                    timer_d = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bits_d  = bits_q + 3'd1;
                    if (bits_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (timer_q == TW'(UART_PERIOD - 1)) begin
                    timer_d = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = WAITHI;
                    end
                end
            end
            WAITHI: begin
                timer_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty     = (count_q == 6'd0);
    assign full      = (count_q == 6'(DEPTH));
    assign wr_status = bus.write_enable && (bus.addr[5:2] == 4'd0);
    assign wr_pop    = bus.write_enable && (bus.addr[5:2] == 4'd2);
    assign pop       = wr_pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs
    assign push_ok   = push && (!full || pop);
    assign ovr_set   = push && full && !pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + AW'(1);
        if (pop)     rptr_d = rptr_q + AW'(1);
        if (push_ok && !pop)      count_d = count_q + 6'd1;
        else if (pop && !push_ok) count_d = count_q - 6'd1;
        ovr_d  = ovr_set  | (ovr_q  & ~(wr_status & bus.data_in[10]));
        ferr_d = ferr_set | (ferr_q & ~(wr_status & bus.data_in[11]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= shift_q;
    end

    always_comb begin
        case (bus.addr[5:2])
            4'd0:    bus.data_out = {20'b0, ferr_q, ovr_q, full, empty,
                                     2'b0, count_q};
            4'd1:    bus.data_out = empty ? 32'd0 : {24'b0, mem_q[rptr_q]};
            default: bus.data_out = 32'd0;
        endcase
    end

    assign bus.irq = !empty;

    assign unused_ok = ^{bus.addr[1:0], bus.data_in[31:12], bus.data_in[9:0]};

endmodule
